// File: rtl/clock_set_controller.sv
// One-second tick generator and two-button set-time sequencer for the 12-hour clock.
// All outputs registered (one cycle after the press/prescaler event); no backpressure, presses are never stalled.
module clock_set_controller #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       tick,
  output logic       adjust_clock,
  output logic [3:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          btn_mode_q;
  logic          btn_inc_q;
  logic          mode_press;
  logic          inc_press;
  logic          tick_nxt;
  logic          adjust_nxt;
  logic          blink_nxt;
  logic [3:0]    hours_nxt;
  logic [5:0]    minutes_nxt;
  logic [5:0]    seconds_nxt;

  // Mode beats inc when both rise in the same cycle.
  assign mode_press = btn_mode & ~btn_mode_q;
  assign inc_press  = btn_inc & ~btn_inc_q & ~mode_press;
  assign mode       = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      unique case (state)
        RUN:   state_nxt = SET_H;
        SET_H: state_nxt = SET_M;
        SET_M: state_nxt = SET_S;
        SET_S: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_nxt     = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    tick_nxt    = 1'b0;
    adjust_nxt  = 1'b0;
    hours_nxt   = set_hours;
    minutes_nxt = set_minutes;
    seconds_nxt = set_seconds;

    if (state_nxt != state) cnt_nxt = '0;
    if (state == RUN && state_nxt == RUN && cnt == CNT_MAX) tick_nxt = 1'b1;
    if (state == SET_S && mode_press) adjust_nxt = 1'b1;

    // Out-of-range clock values would otherwise leave the editor stuck outside 0..11/0..59.
    if (state == RUN && mode_press) begin
      hours_nxt   = (cur_hours > 4'd11)   ? 4'd0 : cur_hours;
      minutes_nxt = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
      seconds_nxt = (cur_seconds > 6'd59) ? 6'd0 : cur_seconds;
    end

    if (inc_press) begin
      unique case (state)
        SET_H:   hours_nxt   = (set_hours == 4'd11)   ? 4'd0 : set_hours + 4'd1;
        SET_M:   minutes_nxt = (set_minutes == 6'd59) ? 6'd0 : set_minutes + 6'd1;
        SET_S:   seconds_nxt = (set_seconds == 6'd59) ? 6'd0 : set_seconds + 6'd1;
        default: ;
      endcase
    end

    // Computed from next-cycle state so the registered blink lines up with the live prescaler.
    blink_nxt = (state_nxt != RUN) && (cnt_nxt < CNT_HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      btn_mode_q   <= 1'b1;
      btn_inc_q    <= 1'b1;
      tick         <= 1'b0;
      adjust_clock <= 1'b0;
      blink        <= 1'b0;
      set_hours    <= 4'd0;
      set_minutes  <= 6'd0;
      set_seconds  <= 6'd0;
    end else begin
      cnt          <= cnt_nxt;
      btn_mode_q   <= btn_mode;
      btn_inc_q    <= btn_inc;
      tick         <= tick_nxt;
      adjust_clock <= adjust_nxt;
      blink        <= blink_nxt;
      set_hours    <= hours_nxt;
      set_minutes  <= minutes_nxt;
      set_seconds  <= seconds_nxt;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: tick/adjust events scoreboarded by cycle, edit state checked directly.
module tb_clock_set_controller;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic       tick;
  logic       adjust_clock;
  logic [3:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic [1:0] mode;
  logic       blink;

  clock_set_controller #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .tick(tick), .adjust_clock(adjust_clock),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         adj;
    int         cyc;
    logic [3:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } sb_ev_t;

  sb_ev_t sbq[$];
  sb_ev_t mon_ev;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;

  // Reference model state
  bit         model_run = 1'b0;
  int         run_base = 0;
  int         ms = 0;
  logic [3:0] e_h = 4'd0;
  logic [5:0] e_m = 6'd0;
  logic [5:0] e_s = 6'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
      mon_ev = sbq.pop_front();
      chk(mon_ev.adj ? "ev_adjust" : "ev_tick", {30'd0, tick, adjust_clock},
          mon_ev.adj ? 32'd1 : 32'd2);
      if (mon_ev.adj)
        chk("adj_set", {16'd0, set_hours, set_minutes, set_seconds}, {16'd0, mon_ev.h, mon_ev.m, mon_ev.s});
    end else if (tick === 1'b1 || adjust_clock === 1'b1) begin
      chk("ev_unexpected", {30'd0, tick, adjust_clock}, 32'd0);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      int nxt;
      nxt = cyc + 1;
      if (model_run && nxt > run_base && ((nxt - run_base) % TD) == 0)
        sbq.push_back('{adj: 1'b0, cyc: nxt, h: 4'd0, m: 6'd0, s: 6'd0});
      @(negedge clk);
    end
  endtask

  // Returns at the first cycle of the new state with btn_mode already released.
  task automatic mode_press();
    step(1);
    btn_mode = 1'b1;
    case (ms)
      0: begin
        model_run = 1'b0;
        e_h = (cur_hours > 4'd11) ? 4'd0 : cur_hours;
        e_m = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
        e_s = (cur_seconds > 6'd59) ? 6'd0 : cur_seconds;
      end
      3: begin
        sbq.push_back('{adj: 1'b1, cyc: cyc + 1, h: e_h, m: e_m, s: e_s});
        model_run = 1'b1;
        run_base  = cyc + 1;
      end
      default: ;
    endcase
    step(1);
    btn_mode = 1'b0;
    ms = (ms + 1) % 4;
  endtask

  task automatic inc_press();
    step(1);
    btn_inc = 1'b1;
    step(1);
    btn_inc = 1'b0;
    case (ms)
      1: e_h = (e_h == 4'd11) ? 4'd0 : e_h + 4'd1;
      2: e_m = (e_m == 6'd59) ? 6'd0 : e_m + 6'd1;
      3: e_s = (e_s == 6'd59) ? 6'd0 : e_s + 6'd1;
      default: ;
    endcase
  endtask

  task automatic chk_set(input string tag);
    chk(tag, {16'd0, set_hours, set_minutes, set_seconds}, {16'd0, e_h, e_m, e_s});
  endtask

  initial begin
    logic [9:0] pat;
    rst_n = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1;
    cur_hours = 4'd0; cur_minutes = 6'd0; cur_seconds = 6'd0;
    step(3);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_tick_adj_blink", {29'd0, tick, adjust_clock, blink}, 32'd0);
    chk_set("rst_set");

    // Free-running RUN, buttons held high since reset
    rst_n = 1'b1; model_run = 1'b1; run_base = cyc;
    step(35);
    chk("run_mode_held", {30'd0, mode}, 32'd0);
    btn_mode = 1'b0; btn_inc = 1'b0;
    step(3);
    chk("run_mode", {30'd0, mode}, 32'd0);

    // Enter SET_H with 3:15:42, blink 5 high / 5 low
    cur_hours = 4'd3; cur_minutes = 6'd15; cur_seconds = 6'd42;
    mode_press();
    chk("enter_mode", {30'd0, mode}, 32'd1);
    chk_set("enter_load");
    pat = '0;
    for (int k = 0; k < TD; k++) begin
      pat[k] = blink;
      step(1);
    end
    chk("blink_pat", {22'd0, pat}, {22'd0, 10'b00000_11111});

    // Commit unchanged, then wrap every field from 11:59:59
    mode_press(); mode_press(); mode_press();
    chk("commit1_mode", {30'd0, mode}, 32'd0);
    step(4);
    cur_hours = 4'd11; cur_minutes = 6'd59; cur_seconds = 6'd59;
    mode_press();
    chk_set("load_max");
    inc_press();
    chk_set("wrap_h");
    mode_press();
    inc_press();
    chk_set("wrap_m");
    mode_press();
    inc_press();
    chk("wrap_s_mode", {30'd0, mode}, 32'd3);
    chk_set("wrap_s");
    mode_press();
    chk("commit2_mode", {30'd0, mode}, 32'd0);
    step(12);

    // Held inc gives one increment
    cur_hours = 4'd5; cur_minutes = 6'd30; cur_seconds = 6'd20;
    mode_press(); mode_press();
    step(1);
    btn_inc = 1'b1;
    step(30);
    btn_inc = 1'b0;
    e_m = e_m + 6'd1;
    step(1);
    chk("held_inc_min", {26'd0, set_minutes}, 32'd31);
    chk_set("held_inc_set");

    // Simultaneous mode+inc in SET_H
    mode_press(); mode_press(); step(5);
    mode_press();
    step(1);
    btn_mode = 1'b1; btn_inc = 1'b1;
    step(1);
    btn_mode = 1'b0; btn_inc = 1'b0;
    ms = 2;
    chk("simul_mode", {30'd0, mode}, 32'd2);
    chk("simul_hours", {28'd0, set_hours}, 32'd5);

    // Reset in SET_S with btn_mode held through release
    mode_press();
    chk("pre_rst_mode", {30'd0, mode}, 32'd3);
    rst_n = 1'b0; btn_mode = 1'b1; model_run = 1'b0;
    step(3);
    ms = 0; e_h = 4'd0; e_m = 6'd0; e_s = 6'd0;
    chk("midrst_mode", {30'd0, mode}, 32'd0);
    chk_set("midrst_set");
    rst_n = 1'b1; model_run = 1'b1; run_base = cyc;
    step(6);
    chk("held_rel_mode", {30'd0, mode}, 32'd0);
    btn_mode = 1'b0;
    step(2);

    // Out-of-range current time loads as zero
    cur_hours = 4'd13; cur_minutes = 6'd60; cur_seconds = 6'd59;
    mode_press();
    chk("oor_hours", {28'd0, set_hours}, 32'd0);
    chk_set("oor_set");
    mode_press(); mode_press(); mode_press();
    step(25);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
